// File: rtl/sterownik_licznika_pkg.sv
// sterownik_licznika_pkg -- shared definitions for the counter sequencer.
//
// Contents:
//   stan_t       FSM state encoding (ST_IDLE, ST_RUN, ST_PAUSE)
//   TRYB_JEDNO   one-shot mode value of tryb
//   TRYB_OKRES   periodic mode value of tryb
//   presk_szer() register width needed to hold 0..n-1 (never below 1 bit)
package sterownik_licznika_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } stan_t;

  localparam logic TRYB_JEDNO = 1'b0;
  localparam logic TRYB_OKRES = 1'b1;

  function automatic int unsigned presk_szer(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sterownik_licznika_if.sv
// sterownik_licznika_if -- control/status bundle of the counter sequencer.
//
// Parameter:
//   W        width of okres and wartosc
// Signals:
//   start    request start (from IDLE) or resume (from PAUSE), level
//   stop     request pause (from RUN) or abort (from PAUSE), level
//   tryb     mode latched at start: 0 one-shot, 1 periodic
//   okres    period latched at start; count runs 0..okres-1
//   wartosc  current count value
//   zajety   high while the sequencer is not idle
//   koniec   one-cycle end-of-period pulse
// Modports:
//   master   the controlling side (drives requests, reads status)
//   slave    the sequencer itself
interface sterownik_licznika_if #(
  parameter int W = 4
);

  logic         start;
  logic         stop;
  logic         tryb;
  logic [W-1:0] okres;
  logic [W-1:0] wartosc;
  logic         zajety;
  logic         koniec;

  modport master (
    output start, stop, tryb, okres,
    input  wartosc, zajety, koniec
  );

  modport slave (
    input  start, stop, tryb, okres,
    output wartosc, zajety, koniec
  );

endinterface

// File: rtl/sterownik_licznika_licznik_en.sv
// licznik_en -- modulo counter with clear and tick enable.
//
// Parameter:
//   W        counter width
// Ports:
//   clk      clock, rising edge
//   res      asynchronous reset, active-low
//   clr      synchronous clear to 0 (wins over en)
//   en       advance on this edge
//   modul    modulus; count runs 0..modul-1 (caller keeps it non-zero while en)
//   wartosc  registered count value
//   wrap     combinational: the current edge (en=1) wraps the count to 0
module licznik_en
  import sterownik_licznika_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         res,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] modul,
  output logic [W-1:0] wartosc,
  output logic         wrap
);

  logic [W-1:0] wartosc_reg;
  logic [W-1:0] szczyt;

  // Last value before wrap, computed in W bits.
  assign szczyt  = modul - W'(1);
  assign wrap    = en && (wartosc_reg == szczyt);
  assign wartosc = wartosc_reg;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wartosc_reg <= '0;
    end else if (clr) begin
      wartosc_reg <= '0;
    end else if (en) begin
      wartosc_reg <= wrap ? '0 : wartosc_reg + W'(1);
    end
  end

endmodule

// File: rtl/sterownik_licznika.sv
// sterownik_licznika -- sequencer around a modulo counter: load period,
// start, pause, resume, abort, one-shot or periodic operation.
//
// Build option:
//   STEROWNIK_PRESKALER_EN  when defined, the count advances once every
//                           PRESK cycles of RUN instead of every cycle.
// Parameters:
//   W        width of period and count value
//   PRESK    prescaler ratio (>= 1), only meaningful with the option above
// Ports:
//   clk      clock, rising edge
//   res      asynchronous reset, active-low; clears all state at once
//   bus      sterownik_licznika_if.slave (start, stop, tryb, okres in;
//            wartosc, zajety, koniec out, all outputs registered)
module sterownik_licznika
  import sterownik_licznika_pkg::*;
#(
  parameter int          W     = 4,
  parameter int unsigned PRESK = 4
) (
  input logic                    clk,
  input logic                    res,
  sterownik_licznika_if.slave    bus
);

  stan_t        stan_reg;
  logic [W-1:0] okres_reg;
  logic         tryb_reg;
  logic         zajety_reg;
  logic         koniec_reg;

  logic         start_ok;   // accepted start from IDLE
  logic         przerwij;   // abort from PAUSE
  logic         wej_pauza;  // RUN -> PAUSE on this edge
  logic         bieg;       // RUN and not being paused
  logic         tick;
  logic         clr;
  logic         wrap;
  logic [W-1:0] wartosc;

  assign start_ok  = (stan_reg == ST_IDLE) && bus.start && !bus.stop &&
                     (bus.okres != '0);
  assign przerwij  = (stan_reg == ST_PAUSE) && bus.stop;
  assign wej_pauza = (stan_reg == ST_RUN) && bus.stop;
  assign bieg      = (stan_reg == ST_RUN) && !bus.stop;
  assign clr       = start_ok || przerwij;

  // A zero prescaler ratio has no meaning; nothing is built for it.
  if (PRESK < 1) begin : g_presk_niepoprawny
  end

`ifdef STEROWNIK_PRESKALER_EN
  localparam int unsigned  PW        = presk_szer(PRESK);
  localparam logic [PW-1:0] PRESK_MAX = PW'(PRESK - 1);

  logic [PW-1:0] presk_reg;

  assign tick = bieg && (presk_reg == PRESK_MAX);

  // Cleared on every entry into a fresh hold window so that each count
  // value, including the one resumed after a pause, lasts PRESK cycles.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      presk_reg <= '0;
    end else if (clr || wej_pauza) begin
      presk_reg <= '0;
    end else if (bieg) begin
      presk_reg <= tick ? '0 : presk_reg + PW'(1);
    end
  end
`else
  assign tick = bieg;
`endif

  licznik_en #(
    .W (W)
  ) u_licznik (
    .clk     (clk),
    .res     (res),
    .clr     (clr),
    .en      (tick),
    .modul   (okres_reg),
    .wartosc (wartosc),
    .wrap    (wrap)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      stan_reg   <= ST_IDLE;
      okres_reg  <= '0;
      tryb_reg   <= TRYB_JEDNO;
      zajety_reg <= 1'b0;
      koniec_reg <= 1'b0;
    end else begin
      koniec_reg <= 1'b0;
      case (stan_reg)
        ST_IDLE: begin
          if (start_ok) begin
            okres_reg  <= bus.okres;
            tryb_reg   <= bus.tryb;
            stan_reg   <= ST_RUN;
            zajety_reg <= 1'b1;
          end
        end
        ST_RUN: begin
          // stop takes priority over a wrap on the same edge
          if (bus.stop) begin
            stan_reg <= ST_PAUSE;
          end else if (wrap) begin
            koniec_reg <= 1'b1;
            if (tryb_reg == TRYB_JEDNO) begin
              stan_reg   <= ST_IDLE;
              zajety_reg <= 1'b0;
            end
          end
        end
        ST_PAUSE: begin
          if (bus.stop) begin
            stan_reg   <= ST_IDLE;
            zajety_reg <= 1'b0;
          end else if (bus.start) begin
            stan_reg <= ST_RUN;
          end
        end
        default: begin
          stan_reg   <= ST_IDLE;
          zajety_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.wartosc = wartosc;
  assign bus.zajety  = zajety_reg;
  assign bus.koniec  = koniec_reg;

endmodule

// File: tb/tb_sterownik_licznika.sv
// tb_sterownik_licznika -- directed self-checking bench for sterownik_licznika.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// With STEROWNIK_PRESKALER_EN defined the prescaler sequence runs instead of
// the cycle-exact sequences.
module tb_sterownik_licznika;
  import sterownik_licznika_pkg::*;

  localparam int W     = 4;
  localparam int PRESK = 4;

  logic clk;
  logic res;

  int n_cmp;
  int n_err;

  sterownik_licznika_if #(.W(W)) bus ();

  sterownik_licznika #(
    .W     (W),
    .PRESK (PRESK)
  ) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic sprawdz(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  // one rising edge, then back to the falling edge for sampling/driving
  task automatic krok();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic stan_wyj(input string tag, input int w, input int z, input int k);
    sprawdz({tag, ".wartosc"}, int'(bus.wartosc), w);
    sprawdz({tag, ".zajety"},  int'(bus.zajety),  z);
    sprawdz({tag, ".koniec"},  int'(bus.koniec),  k);
    $display("%s: wartosc=%0d zajety=%0d koniec=%0d", tag, bus.wartosc, bus.zajety, bus.koniec);
  endtask

  task automatic start_puls(input logic [W-1:0] okres, input logic tryb);
    bus.okres = okres;
    bus.tryb  = tryb;
    bus.start = 1'b1;
    krok();
    bus.start = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    res       = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.tryb  = TRYB_JEDNO;
    bus.okres = '0;
    @(negedge clk);
    stan_wyj("reset", 0, 0, 0);
    res = 1'b1;
    krok();

    // start with okres=0 is ignored
    start_puls(4'd0, TRYB_OKRES);
    stan_wyj("okres0", 0, 0, 0);

    // start and stop together: stop wins
    bus.stop = 1'b1;
    start_puls(4'd5, TRYB_OKRES);
    bus.stop = 1'b0;
    stan_wyj("start_stop", 0, 0, 0);

`ifdef STEROWNIK_PRESKALER_EN
    // okres=3 periodic, each value held PRESK cycles, koniec every 12 cycles
    start_puls(4'd3, TRYB_OKRES);
    stan_wyj("presk_c0", 0, 1, 0);
    for (int c = 1; c <= 26; c++) begin
      krok();
      stan_wyj($sformatf("presk_c%0d", c), (c / 4) % 3, 1, (c % 12 == 0) ? 1 : 0);
    end
    // pause and resume restart the 4-cycle hold of the current value (0)
    bus.stop = 1'b1;
    krok();
    bus.stop = 1'b0;
    stan_wyj("presk_pauza", 0, 1, 0);
    start_puls(4'd9, TRYB_JEDNO);
    stan_wyj("presk_wznow", 0, 1, 0);
    for (int c = 1; c <= 4; c++) begin
      krok();
      stan_wyj($sformatf("presk_po_wznow%0d", c), (c == 4) ? 1 : 0, 1, 0);
    end
`else
    // one-shot okres=3
    start_puls(4'd3, TRYB_JEDNO);
    stan_wyj("jedno_0", 0, 1, 0);
    krok(); stan_wyj("jedno_1", 1, 1, 0);
    krok(); stan_wyj("jedno_2", 2, 1, 0);
    krok(); stan_wyj("jedno_wrap", 0, 0, 1);
    krok(); stan_wyj("jedno_po", 0, 0, 0);

    // periodic okres=12; start/okres/tryb changes during RUN have no effect
    start_puls(4'd12, TRYB_OKRES);
    stan_wyj("okres_c0", 0, 1, 0);
    bus.start = 1'b1;
    bus.okres = 4'd3;
    bus.tryb  = TRYB_JEDNO;
    for (int c = 1; c <= 29; c++) begin
      krok();
      stan_wyj($sformatf("okres_c%0d", c), c % 12, 1, (c % 12 == 0) ? 1 : 0);
    end
    bus.start = 1'b0;

    // pause at 5, hold for 3 cycles, resume, then pause and abort
    bus.stop = 1'b1;
    krok();
    bus.stop = 1'b0;
    stan_wyj("pauza", 5, 1, 0);
    for (int c = 1; c <= 3; c++) begin
      krok();
      stan_wyj($sformatf("pauza_trzyma%0d", c), 5, 1, 0);
    end
    start_puls(4'd9, TRYB_JEDNO);
    stan_wyj("wznow", 5, 1, 0);
    krok(); stan_wyj("wznow_6", 6, 1, 0);
    bus.stop = 1'b1;
    krok(); stan_wyj("pauza2", 6, 1, 0);
    krok(); stan_wyj("przerwij", 0, 0, 0);
    bus.stop = 1'b0;
    krok(); stan_wyj("przerwij_po", 0, 0, 0);

    // stop on the wrap cycle: pause wins, no koniec
    start_puls(4'd3, TRYB_OKRES);
    krok();
    krok(); stan_wyj("wrap_przed", 2, 1, 0);
    bus.stop = 1'b1;
    krok();
    bus.stop = 1'b0;
    stan_wyj("wrap_stop", 2, 1, 0);
    krok(); stan_wyj("wrap_trzyma", 2, 1, 0);
    bus.stop = 1'b1;
    krok();
    bus.stop = 1'b0;
    stan_wyj("wrap_przerwij", 0, 0, 0);

    // okres=1 periodic: koniec every cycle, wartosc stays 0
    start_puls(4'd1, TRYB_OKRES);
    stan_wyj("jeden_c0", 0, 1, 0);
    for (int c = 1; c <= 4; c++) begin
      krok();
      stan_wyj($sformatf("jeden_c%0d", c), 0, 1, 1);
    end
    bus.stop = 1'b1;
    krok();
    krok();
    bus.stop = 1'b0;
    stan_wyj("jeden_koniec", 0, 0, 0);

    // asynchronous reset mid-RUN at wartosc=5
    start_puls(4'd12, TRYB_OKRES);
    for (int c = 1; c <= 5; c++) krok();
    stan_wyj("res_przed", 5, 1, 0);
    #2;
    res = 1'b0;
    #1;
    stan_wyj("res_natych", 0, 0, 0);
    @(negedge clk);
    res = 1'b1;
    krok(); stan_wyj("res_po1", 0, 0, 0);
    krok(); stan_wyj("res_po2", 0, 0, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
